fifo: RTL and testbench

//  Synchronous single-clock circular-buffer FIFO with valid/ready handshakes on both sides.

---
 rtl/fifo.sv | 69 ++++++
 tb/tb_fifo.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fifo.sv
// Single-clock circular-buffer FIFO with valid/ready handshakes on both ports.
// One slot is kept unused so full and empty are distinguishable from the pointers alone.
module fifo #(
  parameter int unsigned data_size   = 10,
  parameter int unsigned buffer_size = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [data_size-1:0] enq_data,
  input  logic                 enq_valid,
  output logic                 enq_ready,
  output logic [data_size-1:0] deq_data,
  output logic                 deq_valid,
  input  logic                 deq_ready,
  input  logic                 flush,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned PW = (buffer_size > 1) ? $clog2(buffer_size) : 1;
  localparam logic [PW-1:0] LAST = PW'(buffer_size - 1);

  logic [data_size-1:0] mem [buffer_size];
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_next;
  logic [PW-1:0]        wr_next;
  logic                 do_enq;
  logic                 do_deq;

  // Wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rd_next   = inc(rd_ptr);
    wr_next   = inc(wr_ptr);
    empty     = (rd_ptr == wr_ptr);
    full      = (wr_next == rd_ptr);
    enq_ready = !full;
    deq_valid = !empty;
    do_enq    = enq_valid && enq_ready;
    do_deq    = deq_ready && deq_valid;
    deq_data  = empty ? '0 : mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int unsigned i = 0; i < buffer_size; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (do_enq) begin
        mem[wr_ptr] <= enq_data;
        wr_ptr      <= wr_next;
      end
      if (do_deq) begin
        rd_ptr <= rd_next;
      end
    end
  end

endmodule

// File: tb/tb_fifo.sv
// Directed self-checking bench for fifo (data_size=10, buffer_size=5).
module tb_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] enq_data;
  logic       enq_valid;
  logic       enq_ready;
  logic [9:0] deq_data;
  logic       deq_valid;
  logic       deq_ready;
  logic       flush;
  logic       full;
  logic       empty;

  int checks = 0;
  int errors = 0;

  fifo #(.data_size(10), .buffer_size(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enq_data  (enq_data),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .deq_data  (deq_data),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .flush     (flush),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int v);
    enq_data  = 10'(v);
    enq_valid = 1'b1;
    tick();
    enq_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enq_data = '0; enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // 1. reset state
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_enq_ready", 32'(enq_ready), 1);
    check("rst_deq_valid", 32'(deq_valid), 0);
    check("rst_deq_data", 32'(deq_data), 0);

    // 2. single word round trip
    push(1);
    check("s2_deq_valid", 32'(deq_valid), 1);
    check("s2_deq_data", 32'(deq_data), 1);
    check("s2_empty", 32'(empty), 0);
    check("s2_full", 32'(full), 0);
    check("s2_enq_ready", 32'(enq_ready), 1);
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    check("s2_empty_after", 32'(empty), 1);
    check("s2_data_after", 32'(deq_data), 0);

    // 3. fill to capacity, then an ignored 5th push
    for (int i = 1; i <= 4; i++) push(i);
    check("s3_full", 32'(full), 1);
    check("s3_enq_ready", 32'(enq_ready), 0);
    check("s3_deq_valid", 32'(deq_valid), 1);
    check("s3_deq_data", 32'(deq_data), 1);
    push(5);
    check("s3_full_hold", 32'(full), 1);
    check("s3_head_hold", 32'(deq_data), 1);

    // 4. drain in order
    deq_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("s4_order", 32'(deq_data), 32'(i));
      tick();
      if (i == 1) begin
        check("s4_full_clr", 32'(full), 0);
        check("s4_enq_ready", 32'(enq_ready), 1);
      end
      check("s4_empty", 32'(empty), (i == 4) ? 1 : 0);
    end
    deq_ready = 1'b0;

    // 5. steady-state occupancy 2 with simultaneous enq/deq, pointers wrap
    push(100);
    push(101);
    for (int k = 0; k < 10; k++) begin
      enq_data  = 10'(102 + k);
      enq_valid = 1'b1;
      deq_ready = 1'b1;
      check("s5_head", 32'(deq_data), 32'(100 + k));
      tick();
      check("s5_valid", 32'(deq_valid), 1);
      check("s5_not_full", 32'(full), 0);
    end
    enq_valid = 1'b0;
    check("s5_tail0", 32'(deq_data), 110);
    tick();
    check("s5_tail1", 32'(deq_data), 111);
    tick();
    deq_ready = 1'b0;
    check("s5_empty", 32'(empty), 1);

    // 6a. flush overrides a same-cycle enqueue
    push(7); push(8); push(9);
    check("s6_head", 32'(deq_data), 7);
    flush = 1'b1;
    push(10);
    flush = 1'b0;
    check("s6_flush_empty", 32'(empty), 1);
    check("s6_flush_valid", 32'(deq_valid), 0);
    check("s6_flush_data", 32'(deq_data), 0);
    push(33);
    check("s6_post_flush", 32'(deq_data), 33);
    check("s6_post_flush_valid", 32'(deq_valid), 1);

    // 6b. reset overrides a same-cycle enqueue
    push(11); push(12);
    rst_n = 1'b0;
    push(13);
    rst_n = 1'b1;
    check("s6_rst_empty", 32'(empty), 1);
    check("s6_rst_full", 32'(full), 0);
    check("s6_rst_data", 32'(deq_data), 0);
    push(44);
    check("s6_post_rst", 32'(deq_data), 44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
